// File: rtl/tilexy_rsp_pkg.sv
// Shared types and constants for the tile X/Y response ring stop.
// Packet layout on the ring is {tag, dst_y, dst_x, data}.
package tilexy_rsp_pkg;

  localparam int COORD_W  = 5;
  localparam int TAG_W    = 8;
  localparam int HDR_W    = TAG_W + 2 * COORD_W;
  localparam int LANE_DEC = 0;
  localparam int LANE_INC = 1;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [COORD_W-1:0] dst_y;
    logic [COORD_W-1:0] dst_x;
  } rsp_hdr_t;

  typedef enum logic [1:0] {
    EJ_LANE0 = 2'd0,
    EJ_LANE1 = 2'd1,
    EJ_LOCAL = 2'd2
  } ej_src_e;

  function automatic int pkt_w(input int dw);
    return dw + HDR_W;
  endfunction

  // Round-robin order for the ejection port: lane0 -> lane1 -> loopback.
  function automatic ej_src_e ej_next(input ej_src_e cur);
    case (cur)
      EJ_LANE0: return EJ_LANE1;
      EJ_LANE1: return EJ_LOCAL;
      default:  return EJ_LANE0;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] pkt_key(input rsp_hdr_t hdr, input logic dim);
    return dim ? hdr.dst_y : hdr.dst_x;
  endfunction

endpackage

// File: rtl/tilexy_rsp_fifo.sv
// Synchronous transit FIFO for one ring lane; head is visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module tilexy_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 530
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tilexy_rsp_ring.sv
// Response-ring stop for one mesh dimension: injects local responses,
// forwards transit in both directions and ejects packets addressed here.
module tilexy_rsp_ring
  import tilexy_rsp_pkg::*;
#(
  parameter int TILE_X = 0,
  parameter int TILE_Y = 0,
  parameter int DIM    = 0,
  parameter int DEPTH  = 8,
  parameter int DW     = 512,
  parameter int STARVE = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rsp_valid,
  output logic                              rsp_ready,
  input  logic [DW-1:0]                     rsp_data,
  input  logic [COORD_W-1:0]                rsp_dst_x,
  input  logic [COORD_W-1:0]                rsp_dst_y,
  input  logic [TAG_W-1:0]                  rsp_tag,
  input  logic [1:0]                        lane_in_vld,
  input  logic [1:0][DW+HDR_W-1:0]          lane_in_pkt,
  output logic [1:0]                        lane_in_rdy,
  output logic [1:0]                        lane_out_vld,
  output logic [1:0][DW+HDR_W-1:0]          lane_out_pkt,
  input  logic [1:0]                        lane_out_rdy,
  output logic                              dlv_valid,
  input  logic                              dlv_ready,
  output logic [DW-1:0]                     dlv_data,
  output logic [TAG_W-1:0]                  dlv_tag,
  output logic [2*COORD_W-1:0]              dlv_src
);

  localparam int PKT_W = pkt_w(DW);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SW    = $clog2(STARVE + 1);
  localparam logic [COORD_W-1:0] OWN = (DIM != 0) ? TILE_Y[COORD_W-1:0] : TILE_X[COORD_W-1:0];
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_CNT = SW'(STARVE);

  typedef struct packed {
    rsp_hdr_t      hdr;
    logic [DW-1:0] data;
  } rsp_pkt_t;

  logic [1:0]             fifo_push;
  logic [1:0]             fifo_pop;
  logic [1:0]             fifo_full;
  logic [1:0]             fifo_empty;
  logic [1:0][CW-1:0]     fifo_count;
  logic [1:0][PKT_W-1:0]  fifo_head;
  rsp_pkt_t [1:0]         head;
  logic [1:0][COORD_W-1:0] head_key;
  logic [1:0]             head_eject;
  logic [1:0]             transit_req;

  rsp_pkt_t               loc_pkt;
  logic [COORD_W-1:0]     loc_key;
  logic [1:0]             loc_req;
  logic                   loc_loop;

  logic [1:0]             lane_load;
  logic [1:0]             take_local;
  logic [1:0]             take_transit;
  logic [1:0]             starve_force;
  logic [1:0][SW-1:0]     starve_cnt;

  logic [2:0]             ej_req;
  ej_src_e                rr_ptr;
  ej_src_e                ej_cand1;
  ej_src_e                ej_cand2;
  ej_src_e                ej_win;
  logic                   ej_any;
  logic                   ej_load;
  logic                   ej_grant;
  rsp_pkt_t               ej_pkt;

  for (genvar d = 0; d < 2; d++) begin : g_lane
    tilexy_rsp_fifo #(
      .DEPTH (DEPTH),
      .W     (PKT_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[d]),
      .push_data (lane_in_pkt[d]),
      .pop       (fifo_pop[d]),
      .head      (fifo_head[d]),
      .full      (fifo_full[d]),
      .empty     (fifo_empty[d]),
      .count     (fifo_count[d])
    );

    // Ready comes from the current count, so a full FIFO refuses even when popping.
    assign lane_in_rdy[d] = (fifo_count[d] != FULL_CNT);
    assign fifo_push[d]   = lane_in_vld[d] && !fifo_full[d];
    assign head[d]        = rsp_pkt_t'(fifo_head[d]);
    assign head_key[d]    = pkt_key(head[d].hdr, DIM != 0);
    assign head_eject[d]  = !fifo_empty[d] && (head_key[d] == OWN);
    assign transit_req[d] = !fifo_empty[d] && (head_key[d] != OWN);
    assign starve_force[d] = (starve_cnt[d] == STARVE_CNT);
  end

  assign loc_pkt            = {rsp_tag, rsp_dst_y, rsp_dst_x, rsp_data};
  assign loc_key            = (DIM != 0) ? rsp_dst_y : rsp_dst_x;
  assign loc_req[LANE_INC]  = rsp_valid && (loc_key > OWN);
  assign loc_req[LANE_DEC]  = rsp_valid && (loc_key < OWN);
  assign loc_loop           = rsp_valid && (loc_key == OWN);

  // Lane output arbitration: transit first, except a starved local takes one slot.
  always_comb begin
    lane_load    = '0;
    take_local   = '0;
    take_transit = '0;
    for (int d = 0; d < 2; d++) begin
      lane_load[d] = !lane_out_vld[d] || lane_out_rdy[d];
      if (lane_load[d]) begin
        if (loc_req[d] && starve_force[d]) begin
          take_local[d] = 1'b1;
        end else if (transit_req[d]) begin
          take_transit[d] = 1'b1;
        end else if (loc_req[d]) begin
          take_local[d] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ej_req   = {loc_loop, head_eject[1], head_eject[0]};
    ej_cand1 = ej_next(rr_ptr);
    ej_cand2 = ej_next(ej_cand1);
    ej_win   = rr_ptr;
    ej_any   = 1'b1;
    if (ej_req[rr_ptr]) begin
      ej_win = rr_ptr;
    end else if (ej_req[ej_cand1]) begin
      ej_win = ej_cand1;
    end else if (ej_req[ej_cand2]) begin
      ej_win = ej_cand2;
    end else begin
      ej_any = 1'b0;
    end
  end

  assign ej_load  = !dlv_valid || dlv_ready;
  assign ej_grant = ej_load && ej_any;

  always_comb begin
    ej_pkt = loc_pkt;
    case (ej_win)
      EJ_LANE0: ej_pkt = head[0];
      EJ_LANE1: ej_pkt = head[1];
      default:  ej_pkt = loc_pkt;
    endcase
  end

  assign fifo_pop[0] = take_transit[0] || (ej_grant && ej_win == EJ_LANE0);
  assign fifo_pop[1] = take_transit[1] || (ej_grant && ej_win == EJ_LANE1);
  assign rsp_ready   = !rst && ((|take_local) || (ej_grant && ej_win == EJ_LOCAL));

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_out_vld <= '0;
      dlv_valid    <= 1'b0;
      rr_ptr       <= EJ_LANE0;
      starve_cnt   <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (lane_load[d]) lane_out_vld[d] <= take_local[d] || take_transit[d];
        if (take_local[d]) begin
          starve_cnt[d] <= '0;
        end else if (loc_req[d] && !starve_force[d]) begin
          starve_cnt[d] <= starve_cnt[d] + 1'b1;
        end
      end
      if (ej_load)  dlv_valid <= ej_any;
      if (ej_grant) rr_ptr <= ej_next(ej_win);
    end
  end

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (take_local[d])        lane_out_pkt[d] <= loc_pkt;
      else if (take_transit[d]) lane_out_pkt[d] <= head[d];
    end
    if (ej_grant) begin
      dlv_data <= ej_pkt.data;
      dlv_tag  <= ej_pkt.hdr.tag;
      dlv_src  <= {ej_pkt.hdr.dst_y, ej_pkt.hdr.dst_x};
    end
  end

endmodule

// File: tb/tb_tilexy_rsp_ring.sv
// Directed bench for tilexy_rsp_ring on the X ring of tile (3,5).
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_tilexy_rsp_ring;

  localparam int DW    = 32;
  localparam int PKT_W = DW + 18;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [4:0]            rsp_dst_x;
  logic [4:0]            rsp_dst_y;
  logic [7:0]            rsp_tag;
  logic [1:0]            lane_in_vld;
  logic [1:0][PKT_W-1:0] lane_in_pkt;
  logic [1:0]            lane_in_rdy;
  logic [1:0]            lane_out_vld;
  logic [1:0][PKT_W-1:0] lane_out_pkt;
  logic [1:0]            lane_out_rdy;
  logic                  dlv_valid;
  logic                  dlv_ready;
  logic [DW-1:0]         dlv_data;
  logic [7:0]            dlv_tag;
  logic [9:0]            dlv_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tilexy_rsp_ring #(
    .TILE_X (3),
    .TILE_Y (5),
    .DIM    (0),
    .DEPTH  (8),
    .DW     (DW),
    .STARVE (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_dst_x    (rsp_dst_x),
    .rsp_dst_y    (rsp_dst_y),
    .rsp_tag      (rsp_tag),
    .lane_in_vld  (lane_in_vld),
    .lane_in_pkt  (lane_in_pkt),
    .lane_in_rdy  (lane_in_rdy),
    .lane_out_vld (lane_out_vld),
    .lane_out_pkt (lane_out_pkt),
    .lane_out_rdy (lane_out_rdy),
    .dlv_valid    (dlv_valid),
    .dlv_ready    (dlv_ready),
    .dlv_data     (dlv_data),
    .dlv_tag      (dlv_tag),
    .dlv_src      (dlv_src)
  );

  function automatic logic [DW-1:0] mk_data(input logic [7:0] tag);
    return {tag ^ 8'hA5, tag, 8'h3C, ~tag};
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [7:0] tag, input logic [4:0] dy, input logic [4:0] dx);
    return {tag, dy, dx, mk_data(tag)};
  endfunction

  function automatic logic [7:0] tag_of(input logic [PKT_W-1:0] p);
    return p[PKT_W-1 -: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [4:0] rdx, input logic [4:0] rdy5,
                               input logic [7:0] rtag, input logic [1:0] lvld,
                               input logic [PKT_W-1:0] p0, input logic [PKT_W-1:0] p1,
                               input logic [1:0] ordy, input logic drdy);
    rsp_valid      = rv;
    rsp_dst_x      = rdx;
    rsp_dst_y      = rdy5;
    rsp_tag        = rtag;
    rsp_data       = mk_data(rtag);
    lane_in_vld    = lvld;
    lane_in_pkt[0] = p0;
    lane_in_pkt[1] = p1;
    lane_out_rdy   = ordy;
    dlv_ready      = drdy;
    @(negedge clk);
  endtask

  task automatic applyIdle(input logic [1:0] ordy);
    applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b00, '0, '0, ordy, 1'b1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyIdle(2'b11);
      nextCycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [1:0] seen;
    rst = 1'b1;
    #1;
    applyReset(2);

    // Reset state
    applyIdle(2'b11);
    checkOutput("rst_lane_out_vld", lane_out_vld, 2'b00);
    checkOutput("rst_dlv_valid", dlv_valid, 1'b0);
    checkOutput("rst_rsp_ready", rsp_ready, 1'b0);
    checkOutput("rst_lane_in_rdy", lane_in_rdy, 2'b11);
    nextCycle();

    // Local injection: dst_x=7 > 3 goes to lane 1, dst_x=0 < 3 to lane 0
    applyStimulus(1'b1, 5'd7, 5'd0, 8'h11, 2'b00, '0, '0, 2'b11, 1'b1);
    checkOutput("loc_inc_ready", rsp_ready, 1'b1);
    nextCycle();
    applyIdle(2'b11);
    checkOutput("loc_inc_vld", lane_out_vld, 2'b10);
    checkOutput("loc_inc_pkt", lane_out_pkt[1], mk_pkt(8'h11, 5'd0, 5'd7));
    nextCycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 8'h12, 2'b00, '0, '0, 2'b11, 1'b1);
    checkOutput("loc_dec_ready", rsp_ready, 1'b1);
    nextCycle();
    applyIdle(2'b11);
    checkOutput("loc_dec_vld", lane_out_vld, 2'b01);
    checkOutput("loc_dec_tag", tag_of(lane_out_pkt[0]), 8'h12);
    nextCycle();

    // Transit ejection on lane 0: visible two cycles after acceptance
    applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b01, mk_pkt(8'h22, 5'd4, 5'd3), '0, 2'b11, 1'b1);
    checkOutput("ej_in_rdy", lane_in_rdy, 2'b11);
    nextCycle();
    applyIdle(2'b11);
    checkOutput("ej_t1_dlv_valid", dlv_valid, 1'b0);
    nextCycle();
    applyIdle(2'b11);
    checkOutput("ej_t2_dlv_valid", dlv_valid, 1'b1);
    checkOutput("ej_t2_dlv_tag", dlv_tag, 8'h22);
    checkOutput("ej_t2_dlv_data", dlv_data, mk_data(8'h22));
    checkOutput("ej_t2_dlv_src", dlv_src, {5'd4, 5'd3});
    checkOutput("ej_t2_lane_out", lane_out_vld, 2'b00);
    nextCycle();

    // Backpressure: 8 in the FIFO plus 1 in the output register, then drain in order
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b10, '0, mk_pkt(8'h30 + 8'(i), 5'd0, 5'd10), 2'b01, 1'b1);
      checkOutput("fill_rdy", lane_in_rdy[1], 1'b1);
      nextCycle();
    end
    applyIdle(2'b01);
    checkOutput("full_rdy", lane_in_rdy[1], 1'b0);
    checkOutput("full_head", {lane_out_vld[1], tag_of(lane_out_pkt[1])}, {1'b1, 8'h30});
    nextCycle();
    for (int j = 0; j < 9; j++) begin
      applyIdle(2'b11);
      checkOutput("drain_order", {lane_out_vld[1], tag_of(lane_out_pkt[1])}, {1'b1, 8'h30 + 8'(j)});
      nextCycle();
    end
    applyIdle(2'b11);
    checkOutput("drain_done_vld", lane_out_vld, 2'b00);
    checkOutput("drain_done_rdy", lane_in_rdy, 2'b11);
    nextCycle();

    // Starvation: local to lane 1 waits 8 blocked cycles, wins on the 9th
    applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b10, '0, mk_pkt(8'h40, 5'd0, 5'd20), 2'b11, 1'b1);
    nextCycle();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 5'd9, 5'd0, 8'h99, 2'b10, '0, mk_pkt(8'h41 + 8'(i), 5'd0, 5'd20), 2'b11, 1'b1);
      checkOutput("starve_ready", rsp_ready, (i == 8) ? 1'b1 : 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b10, '0, mk_pkt(8'h4A, 5'd0, 5'd20), 2'b11, 1'b1);
    checkOutput("starve_local_pkt", lane_out_pkt[1], mk_pkt(8'h99, 5'd0, 5'd9));
    nextCycle();
    applyIdle(2'b11);
    checkOutput("starve_resume", {lane_out_vld[1], tag_of(lane_out_pkt[1])}, {1'b1, 8'h48});
    nextCycle();
    for (int i = 0; i < 6; i++) begin
      applyIdle(2'b11);
      nextCycle();
    end
    applyIdle(2'b11);
    checkOutput("starve_drained", {lane_in_rdy, lane_out_vld}, {2'b11, 2'b00});
    nextCycle();

    // Ejection round robin: lane0, lane1, loopback (dst_y ignored on the X ring)
    applyReset(1);
    applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b11, mk_pkt(8'h50, 5'd1, 5'd3), mk_pkt(8'h51, 5'd2, 5'd3), 2'b11, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 5'd9, 8'h5F, 2'b00, '0, '0, 2'b11, 1'b1);
    checkOutput("rr_c1_ready", rsp_ready, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 5'd9, 8'h5F, 2'b00, '0, '0, 2'b11, 1'b1);
    checkOutput("rr_c2_ready", rsp_ready, 1'b0);
    checkOutput("rr_lane0", {dlv_valid, dlv_tag}, {1'b1, 8'h50});
    nextCycle();
    applyStimulus(1'b1, 5'd3, 5'd9, 8'h5F, 2'b00, '0, '0, 2'b11, 1'b1);
    checkOutput("rr_c3_ready", rsp_ready, 1'b1);
    checkOutput("rr_lane1", {dlv_valid, dlv_tag}, {1'b1, 8'h51});
    nextCycle();
    applyIdle(2'b11);
    checkOutput("rr_loopback", {dlv_valid, dlv_tag}, {1'b1, 8'h5F});
    checkOutput("rr_loopback_src", dlv_src, {5'd9, 5'd3});
    checkOutput("rr_no_lane_out", lane_out_vld, 2'b00);
    nextCycle();
    applyIdle(2'b11);
    checkOutput("rr_done", dlv_valid, 1'b0);
    nextCycle();

    // Reset mid-operation with both lanes partly filled
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 8'h00, 2'b11, mk_pkt(8'h60 + 8'(i), 5'd0, 5'd1),
                    mk_pkt(8'h70 + 8'(i), 5'd0, 5'd20), 2'b00, 1'b1);
      nextCycle();
    end
    applyIdle(2'b00);
    checkOutput("pre_rst_vld", lane_out_vld, 2'b11);
    nextCycle();
    rst = 1'b1;
    applyIdle(2'b00);
    nextCycle();
    rst = 1'b0;
    applyIdle(2'b11);
    checkOutput("mid_rst_vld", lane_out_vld, 2'b00);
    checkOutput("mid_rst_dlv", dlv_valid, 1'b0);
    checkOutput("mid_rst_rdy", lane_in_rdy, 2'b11);
    checkOutput("mid_rst_rsp_ready", rsp_ready, 1'b0);
    nextCycle();
    seen = 2'b00;
    for (int i = 0; i < 12; i++) begin
      applyIdle(2'b11);
      seen = seen | lane_out_vld | {1'b0, dlv_valid};
      nextCycle();
    end
    checkOutput("mid_rst_no_stale", seen, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tilexy_rsp_ring.md
Name: tilexy_rsp_ring

Overview:
- Return-path ring stop. It carries read/ack responses from the tile that serviced a request back toward the requesting tile, along one mesh dimension.
- One instance per dimension per tile: DIM=0 for the X ring, DIM=1 for the Y ring.
- Functions: accepts local responses for injection, forwards transit traffic in both ring directions, and ejects packets whose destination coordinate equals this tile.
- It is the responder-side counterpart of the request ring FIFO, which delivers requests into the tile.

Parameters:
- TILE_X, 0, this tile's X coordinate (5 bits used)
- TILE_Y, 0, this tile's Y coordinate (5 bits used)
- DIM, 0, ring dimension: 0 compares dst_x, 1 compares dst_y
- DEPTH, 8, transit FIFO entries per lane (power of 2, minimum 2)
- DW, 512, response payload width
- STARVE, 8, number of consecutive blocked cycles before local injection is forced

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rsp_valid  in  1  local response offered
- rsp_ready  out  1  local response accepted this cycle
- rsp_data  in  DW  payload
- rsp_dst_x  in  5  destination tile X
- rsp_dst_y  in  5  destination tile Y
- rsp_tag  in  8  request tag
- lane_in_vld  in  2  per lane: [0] decreasing-coordinate lane, [1] increasing
- lane_in_pkt  in  2xPKT_W  incoming packets
- lane_in_rdy  out  2  per-lane FIFO not full
- lane_out_vld  out  2  outgoing packet valid
- lane_out_pkt  out  2xPKT_W  outgoing packets
- lane_out_rdy  in  2  downstream accepts
- dlv_valid  out  1  ejected response valid
- dlv_ready  in  1  local sink accepts
- dlv_data  out  DW  ejected payload
- dlv_tag  out  8  ejected tag
- dlv_src  out  10  {dst_y,dst_x} of the ejected packet (for check)

Behaviour:
- Packet format: {tag[7:0], dst_y[4:0], dst_x[4:0], data[DW-1:0]}; PKT_W = DW+18.
- Coordinate: key = DIM ? dst_y : dst_x; own = DIM ? TILE_Y : TILE_X.
- Lane input:
  - lane_in_rdy[d] = !full[d], combinational from the FIFO count.
  - A transfer occurs when vld & rdy; the packet is written into FIFO d at that edge.
- Transit head of lane d, if key == own: requests ejection. Otherwise it requests lane_out d (same direction continues).
- Local injection routing:
  - key > own: lane 1
  - key < own: lane 0
  - key == own: loopback to ejection
- Lane output register d:
  - Loads when !lane_out_vld[d] | lane_out_rdy[d].
  - Source priority: transit head first, local second. The exception is starve-force: when the starvation counter for lane d has reached STARVE, local wins one slot and the counter clears.
  - Starvation counter d: increments each cycle that rsp_valid targets lane d and is not granted; clears on grant; saturates at STARVE.
- Ejection register (dlv_*):
  - Loads when !dlv_valid | dlv_ready.
  - Round-robin among lane0 head, lane1 head and loopback. The pointer advances past the winner only on grant.
- rsp_ready is high in the cycle the chosen target (lane reg or ejection reg) grants local. A FIFO pops in the cycle its head is granted.
- Latency (no backpressure):
  - lane_in accepted at cycle t: lane_out_vld or dlv_valid at t+2.
  - Local accepted at t: output valid at t+1.
- Ordering: per lane, transit packets leave in arrival order. Local packets to the same destination leave in acceptance order.
- FIFO boundaries:
  - Full with a simultaneous pop: the push is still refused in that cycle (rdy comes from the current count).
  - Empty: no request.
  - Pointers wrap modulo DEPTH.
- Reset values:
  - lane_out_vld = 0, dlv_valid = 0, rsp_ready = 0, lane_in_rdy = 2'b11 after reset.
  - FIFOs empty, RR pointer = lane0, starvation counters = 0.
  - Reset asserted mid-operation drops all in-flight packets; data registers are don't-care.
- Packet fields pass through unmodified. No coordinate arithmetic beyond unsigned 5-bit compare.

Decomposition:
- Package tilexy_rsp_pkg:
  - rsp_pkt_t struct (tag, dst_y, dst_x, data)
  - PKT_W, COORD_W=5, TAG_W=8, lane index constants LANE_DEC=0, LANE_INC=1
- Sub-module tilexy_rsp_fifo: synchronous DEPTH-entry FIFO with push/pop/full/empty/count. Instantiated twice.

Test Plan:
- TILE_X=3, DIM=0, local rsp dst_x=7 tag=0x11 -> lane_out_vld[1]=1 next cycle with tag 0x11; lane_out_vld[0]=0.
- lane_in_vld[0] packet dst_x=3 tag=0x22, dlv_ready=1 -> dlv_valid 2 cycles later, dlv_tag=0x22, nothing on lane_out.
- lane_out_rdy[1]=0 with 9 transit packets streaming on lane 1 -> lane_in_rdy[1] drops after 8 accepted plus the 1 held in the output register. Raise rdy -> all 9 exit in order.
- Continuous transit on lane 1 plus local rsp dst_x=9 held -> local granted on exactly the 9th blocked cycle (STARVE=8), then transit resumes.
- Lane0, lane1 and local loopback all targeting ejection simultaneously, dlv_ready=1 -> grants rotate lane0, lane1, loopback across 3 consecutive cycles.
- Assert rst for 1 cycle with both FIFOs half full -> next cycle all valids 0, lane_in_rdy=2'b11, no stale packet is ever emitted.
